// File: rtl/memtrace_lane_coalescer_if.sv
// Bundle of the trace-source handshake, the merged memory request port and the status outputs
// of the lane coalescer.
//   slave  : the coalescer side (consumes trace bundles, drives memory requests and status)
//   master : the environment side (trace source + memory model)
interface memtrace_lane_coalescer_if #(
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned MAX_INFLIGHT = 4
);
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_THREADS-1:0]        trace_valid;
  logic [ADDR_W*NUM_THREADS-1:0] trace_address;
  logic                          trace_finished;
  logic                          trace_ready;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [ADDR_W-1:0]             mem_req_addr;
  logic [NUM_THREADS-1:0]        mem_req_mask;
  logic                          mem_resp_valid;
  logic [CntW-1:0]               inflight;
  logic                          done;
  logic                          err;

  modport slave (
    input  trace_valid, trace_address, trace_finished, mem_req_ready, mem_resp_valid,
    output trace_ready, mem_req_valid, mem_req_addr, mem_req_mask, inflight, done, err
  );

  modport master (
    output trace_valid, trace_address, trace_finished, mem_req_ready, mem_resp_valid,
    input  trace_ready, mem_req_valid, mem_req_addr, mem_req_mask, inflight, done, err
  );
endinterface

// File: rtl/memtrace_lane_coalescer.sv
// Lane coalescer for memory-trace bundles.
// Accepts one per-thread request bundle at a time, merges lanes that fall in the same
// LINE_BYTES-aligned line, and issues the merged requests one per handshake on a single
// valid/ready memory port. Counts outstanding requests and raises a sticky done once the
// trace source has finished and every request has been answered.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : trace_valid/trace_address/trace_finished/trace_ready from the trace source,
//                  mem_req_valid/ready/addr/mask to memory, mem_resp_valid from memory,
//                  inflight count, sticky done and err status
module memtrace_lane_coalescer #(
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned LINE_BYTES   = 64,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  memtrace_lane_coalescer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CntW-1:0]   MaxCnt   = CntW'(MAX_INFLIGHT);
  localparam logic [ADDR_W-1:0] LineMask = ~(ADDR_W'(LINE_BYTES - 1));

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                                state_q, state_d;
  logic [NUM_THREADS-1:0][ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_THREADS-1:0]                pending_q, pending_d;
  logic                                  fin_seen_q, fin_seen_d;
  logic [CntW-1:0]                       inflight_q, inflight_d;
  logic                                  err_q, err_d;

  logic [ADDR_W-1:0]      leader_line;
  logic [NUM_THREADS-1:0] req_mask;
  logic                   req_valid;
  logic                   fire;
  logic                   retire;
  logic                   accept;

  // Leader is the lowest-index pending lane; scanning downwards lets the lowest one win.
  always_comb begin
    leader_line = '0;
    for (int g = NUM_THREADS - 1; g >= 0; g--) begin
      if (pending_q[g]) leader_line = addr_q[g] & LineMask;
    end
    req_mask = '0;
    for (int g = 0; g < NUM_THREADS; g++) begin
      req_mask[g] = pending_q[g] && ((addr_q[g] & LineMask) == leader_line);
    end
  end

  assign req_valid = !reset && (state_q == StIssue) && (inflight_q < MaxCnt);
  assign fire      = req_valid && bus.mem_req_ready;
  // A response with nothing outstanding retires nothing and only flags an error.
  assign retire    = bus.mem_resp_valid && (inflight_q != '0);
  assign accept    = !reset && (state_q == StIdle) && (|bus.trace_valid);

  always_comb begin
    inflight_d = inflight_q + CntW'(fire) - CntW'(retire);
    err_d      = err_q || (bus.mem_resp_valid && (inflight_q == '0));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pending_d  = pending_q;
    fin_seen_d = fin_seen_q;
    unique case (state_q)
      StIdle: begin
        fin_seen_d = fin_seen_q || bus.trace_finished;
        if (accept) begin
          addr_d    = bus.trace_address;
          pending_d = bus.trace_valid;
          state_d   = StIssue;
        end else if (fin_seen_d) begin
          state_d = (inflight_d == '0) ? StDone : StDrain;
        end
      end
      StIssue: begin
        if (fire) begin
          pending_d = pending_q & ~req_mask;
          if (pending_d == '0) begin
            if (!fin_seen_q)              state_d = StIdle;
            else if (inflight_d == '0)    state_d = StDone;
            else                          state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (inflight_d == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      pending_q  <= '0;
      fin_seen_q <= 1'b0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
      fin_seen_q <= fin_seen_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign bus.trace_ready   = !reset && (state_q == StIdle);
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = leader_line;
  assign bus.mem_req_mask  = req_mask;
  assign bus.inflight      = inflight_q;
  assign bus.done          = (state_q == StDone);
  assign bus.err           = err_q;

endmodule

// File: tb/tb_memtrace_lane_coalescer.sv
module tb_memtrace_lane_coalescer;
  localparam int unsigned NT = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned LB = 64;
  localparam int unsigned MI = 4;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [AW+NT-1:0] exp_q[$];  // {line address, lane mask}

  memtrace_lane_coalescer_if #(.NUM_THREADS(NT), .ADDR_W(AW), .MAX_INFLIGHT(MI)) bus ();

  memtrace_lane_coalescer #(
    .NUM_THREADS (NT),
    .ADDR_W      (AW),
    .LINE_BYTES  (LB),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference coalescing: repeatedly take the lowest pending lane and gather its line.
  task automatic push_expected(input logic [NT-1:0] v, input logic [AW-1:0] a[NT]);
    logic [NT-1:0] pend;
    logic [AW-1:0] line;
    logic [NT-1:0] m;
    int            lead;
    pend = v;
    while (pend != '0) begin
      lead = 0;
      while (!pend[lead]) lead++;
      line = a[lead] - (a[lead] % LB);
      m    = '0;
      for (int g = 0; g < NT; g++) begin
        if (pend[g] && ((a[g] - (a[g] % LB)) == line)) m[g] = 1'b1;
      end
      exp_q.push_back({line, m});
      pend = pend & ~m;
    end
  endtask

  // Scoreboard: every handshake must match the next expected merged request.
  always @(negedge clock) begin
    if (!reset && bus.mem_req_valid && bus.mem_req_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", 64'(bus.mem_req_addr), 64'hdead);
      end else begin
        logic [AW+NT-1:0] e;
        e = exp_q.pop_front();
        check("req_addr", 64'(bus.mem_req_addr), 64'(e[AW+NT-1:NT]));
        check("req_mask", 64'(bus.mem_req_mask), 64'(e[NT-1:0]));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.trace_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.trace_ready) check("ready_timeout", 64'(bus.trace_ready), 64'd1);
  endtask

  // Returns at posedge+1 of the accept edge.
  task automatic send_bundle(input logic [NT-1:0] v, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [AW-1:0] a3);
    logic [AW-1:0] a[NT];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    wait_ready();
    bus.trace_valid   = v;
    bus.trace_address = {a3, a2, a1, a0};
    push_expected(v, a);
    @(posedge clock);
    #1 bus.trace_valid = '0;
  endtask

  task automatic respond(input int n);
    @(negedge clock);
    bus.mem_resp_valid = 1'b1;
    repeat (n) @(posedge clock);
    #1 bus.mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.trace_valid    = '0;
    bus.trace_address  = '0;
    bus.trace_finished = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_trace_ready", 64'(bus.trace_ready), 64'd0);
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_inflight", 64'(bus.inflight), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_ready_after", 64'(bus.trace_ready), 64'd1);

    // A: all four lanes in one line
    bus.mem_req_ready = 1'b1;
    send_bundle(4'b1111, 64'h1000, 64'h1008, 64'h1010, 64'h1038);
    @(negedge clock);
    check("a_valid", 64'(bus.mem_req_valid), 64'd1);
    check("a_busy", 64'(bus.trace_ready), 64'd0);
    @(negedge clock);
    check("a_ready_after_fire", 64'(bus.trace_ready), 64'd1);
    check("a_inflight", 64'(bus.inflight), 64'd1);
    respond(1);

    // B: three lines, three consecutive fires
    send_bundle(4'b1111, 64'h1000, 64'h2000, 64'h1040, 64'h2010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("b_consecutive_valid", 64'(bus.mem_req_valid), 64'd1);
    end
    @(negedge clock);
    check("b_inflight", 64'(bus.inflight), 64'd3);
    check("b_ready", 64'(bus.trace_ready), 64'd1);
    respond(3);

    // C: back-pressure keeps the request stable
    bus.mem_req_ready = 1'b0;
    send_bundle(4'b0110, 64'h9999, 64'h3000, 64'h3020, 64'h5555);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("c_hold_valid", 64'(bus.mem_req_valid), 64'd1);
      check("c_hold_addr", 64'(bus.mem_req_addr), 64'h3000);
      check("c_hold_mask", 64'(bus.mem_req_mask), 64'b0110);
    end
    @(posedge clock);
    #1 bus.mem_req_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("c_single_fire", 64'(bus.mem_req_valid), 64'd0);
    check("c_inflight", 64'(bus.inflight), 64'd1);
    respond(1);
    @(negedge clock);
    check("c_drained", 64'(bus.inflight), 64'd0);

    // D: inflight cap
    for (int i = 0; i < 5; i++) begin
      send_bundle(4'b0001, 64'h4000 + 64'(i) * 64'h1000, 64'h0, 64'h0, 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("d_cap_inflight", 64'(bus.inflight), 64'd4);
      check("d_cap_valid", 64'(bus.mem_req_valid), 64'd0);
    end
    respond(1);
    @(negedge clock);
    check("d_after_resp_inflight", 64'(bus.inflight), 64'd3);
    check("d_after_resp_valid", 64'(bus.mem_req_valid), 64'd1);
    @(negedge clock);
    check("d_refill_inflight", 64'(bus.inflight), 64'd4);
    check("d_refill_valid", 64'(bus.mem_req_valid), 64'd0);
    respond(4);
    @(negedge clock);
    check("d_drained", 64'(bus.inflight), 64'd0);

    // E: finish with two outstanding, then drain
    send_bundle(4'b0001, 64'h8000, 64'h0, 64'h0, 64'h0);
    send_bundle(4'b0001, 64'h9000, 64'h0, 64'h0, 64'h0);
    wait_ready();
    check("e_inflight_pre", 64'(bus.inflight), 64'd2);
    bus.trace_finished = 1'b1;
    @(posedge clock);
    #1 bus.trace_finished = 1'b0;
    @(negedge clock);
    check("e_drain_ready", 64'(bus.trace_ready), 64'd0);
    check("e_drain_done", 64'(bus.done), 64'd0);
    respond(1);
    @(negedge clock);
    check("e_one_left", 64'(bus.inflight), 64'd1);
    check("e_not_done", 64'(bus.done), 64'd0);
    respond(1);
    @(negedge clock);
    check("e_done", 64'(bus.done), 64'd1);
    check("e_err_clear", 64'(bus.err), 64'd0);
    respond(1);
    @(negedge clock);
    check("e_err_set", 64'(bus.err), 64'd1);
    check("e_done_sticky", 64'(bus.done), 64'd1);
    check("e_inflight_zero", 64'(bus.inflight), 64'd0);
    check("e_done_no_ready", 64'(bus.trace_ready), 64'd0);

    // F: reset while issuing with pending lanes 1 and 3
    do_reset();
    respond(1);
    @(negedge clock);
    check("f_err_idle", 64'(bus.err), 64'd1);
    bus.mem_req_ready = 1'b0;
    send_bundle(4'b1010, 64'h0, 64'h6000, 64'h0, 64'h7000);
    @(negedge clock);
    check("f_issue_valid", 64'(bus.mem_req_valid), 64'd1);
    check("f_issue_mask", 64'(bus.mem_req_mask), 64'b0010);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("f_rst_valid", 64'(bus.mem_req_valid), 64'd0);
    check("f_rst_inflight", 64'(bus.inflight), 64'd0);
    check("f_rst_done", 64'(bus.done), 64'd0);
    check("f_rst_err", 64'(bus.err), 64'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    check("f_ready_after", 64'(bus.trace_ready), 64'd1);
    check("f_valid_after", 64'(bus.mem_req_valid), 64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
